// File: rtl/ctrl_mem_write_pp_pkg.sv
// Shared types and constants for the ping-pong operand-memory write controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

  localparam int NUM_BUFS = 2;

  // Width needed to hold a fill length of 0..mem_size inclusive.
  function automatic int len_width(input int mem_size);
    return $clog2(mem_size + 1);
  endfunction

endpackage

// File: rtl/ctrl_mem_write_pp_if.sv
// Stream, memory-write, buffer-status and release signals of the ping-pong write controller.
interface ctrl_mem_write_pp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int LEN_WIDTH  = 4
);
  import mem_ctrl_pkg::*;

  logic                           s_valid;
  logic [DATA_WIDTH-1:0]          s_data;
  logic                           s_last;
  logic                           s_ready;
  logic                           mem_wr_en;
  logic                           mem_wr_sel;
  logic [ADDR_WIDTH-1:0]          mem_wr_addr;
  logic [DATA_WIDTH-1:0]          mem_wr_data;
  logic [NUM_BUFS-1:0]            buf_full;
  logic [NUM_BUFS*LEN_WIDTH-1:0]  buf_len;
  logic                           rel_valid;
  logic                           rel_idx;
  logic [LEN_WIDTH-1:0]           wr_count;

  modport master (
    output s_valid, s_data, s_last, rel_valid, rel_idx,
    input  s_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
           buf_full, buf_len, wr_count
  );

  modport slave (
    input  s_valid, s_data, s_last, rel_valid, rel_idx,
    output s_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
           buf_full, buf_len, wr_count
  );

endinterface

// File: rtl/ctrl_mem_write_pp_buf_state_tracker.sv
// Lifecycle of one operand buffer: EMPTY -> FILLING -> FULL -> EMPTY, plus its fill length.
module buf_state_tracker
  import mem_ctrl_pkg::*;
#(
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 close,
  input  logic [LEN_WIDTH-1:0] close_len,
  input  logic                 release_req,
  output buf_state_t           state,
  output logic                 full,
  output logic [LEN_WIDTH-1:0] len
);

  // NOTE: non-blocking assignments keep every tracker and the top-level
  // pointer working from the same pre-edge values within a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUF_EMPTY;
      len   <= '0;
    end else if (close) begin
      // A single-word frame closes straight from EMPTY, so close wins over start.
      state <= BUF_FULL;
      len   <= close_len;
    end else if (start && state == BUF_EMPTY) begin
      state <= BUF_FILLING;
    end else if (release_req && state == BUF_FULL) begin
      state <= BUF_EMPTY;
    end
  end

  assign full = (state == BUF_FULL);

endmodule

// File: rtl/ctrl_mem_write_pp.sv
// Ping-pong write controller: streams words alternately into two buffers and hands them to compute.
module ctrl_mem_write_pp
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 8,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int LEN_WIDTH  = len_width(MEM_SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_mem_write_pp_if.slave bus
);

  logic                 wr_sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic                 accept;
  logic                 close;
  logic [LEN_WIDTH-1:0] close_len;
  buf_state_t           state [NUM_BUFS];
  logic [NUM_BUFS-1:0]  full;
  logic [LEN_WIDTH-1:0] len   [NUM_BUFS];

  // Ready comes only from registered buffer state, never from s_valid.
  assign bus.s_ready = (state[wr_sel] != BUF_FULL);
  assign accept      = bus.s_valid & bus.s_ready;
  assign close       = accept & ((addr == ADDR_WIDTH'(MEM_SIZE - 1)) | bus.s_last);
  assign close_len   = LEN_WIDTH'(addr) + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel <= 1'b0;
      addr   <= '0;
    end else if (close) begin
      wr_sel <= ~wr_sel;
      addr   <= '0;
    end else if (accept) begin
      addr <= addr + ADDR_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
    buf_state_tracker #(.LEN_WIDTH(LEN_WIDTH)) u_tracker (
      .clk         (clk),
      .reset       (reset),
      .start       (accept && (wr_sel == 1'(g))),
      .close       (close && (wr_sel == 1'(g))),
      .close_len   (close_len),
      .release_req (bus.rel_valid && (bus.rel_idx == 1'(g))),
      .state       (state[g]),
      .full        (full[g]),
      .len         (len[g])
    );
    assign bus.buf_len[g*LEN_WIDTH +: LEN_WIDTH] = len[g];
  end

  assign bus.mem_wr_en   = accept;
  assign bus.mem_wr_sel  = wr_sel;
  assign bus.mem_wr_addr = addr;
  assign bus.mem_wr_data = bus.s_data;
  assign bus.buf_full    = full;
  assign bus.wr_count    = LEN_WIDTH'(addr);

endmodule

// File: doc/ctrl_mem_write_pp.md
Name: ctrl_mem_write_pp

Overview:
Parametrised ping-pong write controller for the operand memories of the matrix-vector engine. It accepts a valid/ready input stream and writes each accepted word into one of two equal memory buffers. Buffers fill alternately, and each is handed to the compute side as FULL. The compute side returns a buffer with a release handshake, so loading of the next operand set overlaps computation on the current one. It adds double buffering, early frame termination (s_last), per-buffer fill length, and generalised data/depth over the single-buffer write controller.

Parameters:
DATA_WIDTH, 16, width of stream data and memory word
MEM_SIZE, 8, words per buffer (>=2)
ADDR_WIDTH, $clog2(MEM_SIZE), per-buffer address width
LEN_WIDTH, $clog2(MEM_SIZE+1), width of fill-length fields

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input word valid
s_data  in  DATA_WIDTH  input word
s_last  in  1  accepted word is last of frame (early close)
s_ready  out  1  controller can accept a word
mem_wr_en  out  1  write strobe (= s_valid & s_ready)
mem_wr_sel  out  1  target buffer of current write
mem_wr_addr  out  ADDR_WIDTH  word address within target buffer
mem_wr_data  out  DATA_WIDTH  = s_data (combinational pass-through)
buf_full  out  2  bit i set: buffer i FULL, readable by compute
buf_len  out  2*LEN_WIDTH  fill length of buffer i at bits [i*LEN_WIDTH +: LEN_WIDTH]
rel_valid  in  1  compute releases a buffer this cycle
rel_idx  in  1  index of released buffer
wr_count  out  LEN_WIDTH  words written so far into current buffer

Behaviour:
- Reset (synchronous, active-high, clock clk): both buffers EMPTY, wr_sel=0, addr=0, buf_full=2'b00, buf_len all 0, wr_count=0.
- s_ready is 1 in the first cycle after reset.
- Reset mid-frame discards the partial frame and any FULL buffers.
- Per-buffer state: EMPTY -> FILLING (first accepted word) -> FULL (close) -> EMPTY (release).
- s_ready = (state[wr_sel] != FULL). It is decoded from registers only and never depends on s_valid.
- Accept: mem_wr_en=1 writes s_data at (wr_sel, addr) in the same cycle, i.e. zero-latency write. After the edge, addr and wr_count increment.
- Close: accepted word with addr==MEM_SIZE-1 OR s_last=1. Next cycle:
  - state[wr_sel]=FULL, buf_full[wr_sel]=1;
  - buf_len[wr_sel]=addr+1;
  - wr_sel toggles; addr=0; wr_count=0.
- s_last on the word at addr MEM_SIZE-1 gives a single close with len=MEM_SIZE.
- s_last on the first word gives len=1.
- Release: rel_valid with state[rel_idx]==FULL sets that buffer EMPTY and buf_full bit 0 next cycle; buf_len is held.
- Release of an EMPTY or FILLING buffer is ignored: no state change.
- Simultaneous close of buffer A and release of buffer B: both take effect. The next cycle has wr_sel=B and s_ready=1.
- Both buffers FULL: s_ready=0 and the stream stalls. s_ready rises the cycle after a valid release of buffer wr_sel.
- s_valid without s_ready: no write, no counter change.
- Arithmetic: addr wraps to 0 only via close. No modular increment past MEM_SIZE-1.

Decomposition:
- Package mem_ctrl_pkg holds:
  - buf_state_t enum {BUF_EMPTY, BUF_FILLING, BUF_FULL}, 2 bits;
  - the NUM_BUFS=2 constant;
  - a function computing LEN_WIDTH.
- Sub-module buf_state_tracker: one instance per buffer. Inputs are clk, reset, start, close, close_len, release. Outputs are state, full, and len.
- Top level holds wr_sel, addr, the handshake, and close detection.

Test Plan:
- MEM_SIZE=8: reset, then 8 back-to-back valid words 0..7 -> addrs 0..7 on sel 0. Next cycle buf_full=01, buf_len0=8, wr_sel=1, s_ready=1.
- Fill buf0 and buf1 (16 words) with no release, keep s_valid=1 -> buf_full=11 and s_ready=0. No mem_wr_en for 5 cycles. rel_valid, rel_idx=0 -> s_ready=1 next cycle and the next write goes to sel 0 addr 0.
- s_last on the 3rd word -> buf_len0=3, buf_full=01. The 4th word goes to sel 1 addr 0.
- Last write of buf1 in the same cycle as release of buf0 (buf0 FULL) -> next cycle buf_full=10, wr_sel=0, s_ready=1.
- Release of the currently FILLING buffer after 4 words -> ignored. The remaining words continue at addr 4..7 and close normally with len=8.
- Reset asserted after 5 words into buf1 with buf0 FULL -> next cycle buf_full=00, wr_sel=0, addr=0, s_ready=1, wr_count=0.
